// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    // Word selects, i_addr[3:2]
    localparam logic [1:0] REG_TX     = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT = 1;
    localparam int unsigned STAT_EMPTY_BIT = 2;
    localparam int unsigned STAT_OVF_BIT  = 3;
    localparam int unsigned STAT_CNT_LSB  = 4;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear and home (0x02 and its 0x03 alias) need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && ((b == CMD_CLEAR) || (b[7:1] == CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Load-store unit peripheral bus as seen by the LCD controller.
interface lcd_ctrl_if;
    logic        i_sel;
    logic [3:0]  i_addr;
    logic        i_wr_en;
    logic        i_rd_en;
    logic [31:0] i_wr_data;
    logic [31:0] o_rd_data;

    modport master (output i_sel, i_addr, i_wr_en, i_rd_en, i_wr_data,
                    input  o_rd_data);
    modport slave  (input  i_sel, i_addr, i_wr_en, i_rd_en, i_wr_data,
                    output o_rd_data);
endinterface

// File: rtl/lcd_cmd_fifo.sv
// Command FIFO; a pop on the same edge frees the slot for a push when full.
module lcd_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lcd_ctrl.sv
// Memory-mapped HD44780-style LCD driver: CPU stores queue bytes, FSM times them onto the pins.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned EN_CYC     = 13,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned EXEC_CYC   = 2000,
    parameter int unsigned LONG_CYC   = 82000,
    parameter int unsigned POR_CYC    = 750000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    lcd_ctrl_if.slave   bus,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_lcd_blon
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    lcd_state_e        state;
    lcd_state_e        state_nxt;
    logic [31:0]       cnt;
    logic [31:0]       lim;
    logic              pop;
    logic [7:0]        lcd_data;
    logic              lcd_rs;
    logic [1:0]        ctrl;
    logic              ovf;
    logic              wr_tx;
    logic              wr_status;
    logic              wr_ctrl;
    logic              busy;
    logic [31:0]       status_word;
    logic [8:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_bits;

    assign wr_tx     = bus.i_sel && bus.i_wr_en && (bus.i_addr[3:2] == REG_TX);
    assign wr_status = bus.i_sel && bus.i_wr_en && (bus.i_addr[3:2] == REG_STATUS);
    assign wr_ctrl   = bus.i_sel && bus.i_wr_en && (bus.i_addr[3:2] == REG_CTRL);
    assign unused_bits = ^{bus.i_addr[1:0], bus.i_wr_data[31:9]};

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (wr_tx),
        .pop   (pop),
        .din   (bus.i_wr_data[8:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register, shared dwell counter (cleared on every state entry) and pin registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_INIT;
            cnt      <= '0;
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || (state == ST_IDLE)) cnt <= '0;
            else                                            cnt <= cnt + 1'b1;
            if (pop) {lcd_rs, lcd_data} <= fifo_dout;
        end
    end

    // Next state and pop; a state whose dwell is N leaves when cnt reaches N-1
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        lim       = '0;
        case (state)
            ST_INIT:  lim = POR_CYC - 1;
            ST_SETUP: lim = SETUP_CYC - 1;
            ST_PULSE: lim = EN_CYC - 1;
            ST_HOLD:  lim = HOLD_CYC - 1;
            ST_WAIT:  lim = is_long_cmd(lcd_rs, lcd_data) ? LONG_CYC - 1 : EXEC_CYC - 1;
            default:  lim = '0;
        endcase
        case (state)
            ST_INIT:  if (cnt == lim) state_nxt = ST_IDLE;
            ST_IDLE:  if (!fifo_empty) begin
                          pop       = 1'b1;
                          state_nxt = ST_SETUP;
                      end
            ST_SETUP: if (cnt == lim) state_nxt = ST_PULSE;
            ST_PULSE: if (cnt == lim) state_nxt = ST_HOLD;
            ST_HOLD:  if (cnt == lim) state_nxt = ST_WAIT;
            ST_WAIT:  if (cnt == lim) state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // Control register and sticky overflow flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl <= '0;
            ovf  <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= bus.i_wr_data[1:0];
            if (wr_status && bus.i_wr_data[STAT_OVF_BIT]) ovf <= 1'b0;
            else if (wr_tx && fifo_full && !pop)          ovf <= 1'b1;
        end
    end

    assign busy = (state != ST_IDLE) || !fifo_empty;

    // STATUS word assembly
    always_comb begin
        status_word                      = '0;
        status_word[STAT_BUSY_BIT]       = busy;
        status_word[STAT_FULL_BIT]       = fifo_full;
        status_word[STAT_EMPTY_BIT]      = fifo_empty;
        status_word[STAT_OVF_BIT]        = ovf;
        status_word[STAT_CNT_LSB +: 4]   = 4'(fifo_count);
    end

    // Combinational read mux, zero when not selected for a load
    always_comb begin
        bus.o_rd_data = '0;
        if (bus.i_sel && bus.i_rd_en) begin
            case (bus.i_addr[3:2])
                REG_STATUS: bus.o_rd_data = status_word;
                REG_CTRL:   bus.o_rd_data = {30'b0, ctrl};
                default:    bus.o_rd_data = '0;
            endcase
        end
    end

    assign o_lcd_data = lcd_data;
    assign o_lcd_rs   = lcd_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = (state == ST_PULSE);
    assign o_lcd_on   = ctrl[0];
    assign o_lcd_blon = ctrl[1];

endmodule
